// File: rtl/dcc_pkg.sv
// Shared definitions for the ADC capture block: FSM state encoding and default sizes.
package dcc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_t;

  localparam int ADC_W     = 14;
  localparam int CAP_DEPTH = 256;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a registered read.
module capture_ram
  import dcc_pkg::*;
#(
  parameter int DATA_W = ADC_W,
  parameter int DEPTH  = CAP_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_capture.sv
// Triggered ADC capture: arm, wait for a rising threshold crossing (or forced trigger),
// store LEN+1 samples, then stream them out over a valid/ready handshake.
module adc_capture
  import dcc_pkg::*;
#(
  parameter int DATA_W = ADC_W,
  parameter int DEPTH  = CAP_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              OSC_50,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] ADC_D,
  input  logic              ADC_OR,
  input  logic              ADC_VALID,
  input  logic              ARM,
  input  logic              FORCE_TRIG,
  input  logic [DATA_W-1:0] THRESHOLD,
  input  logic [AW-1:0]     LEN,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic              RD_LAST,
  output logic [1:0]        STATE,
  output logic [7:0]        OR_COUNT,
  output logic              DONE
);

  state_t            state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              force_pend;
  logic              rd_all_issued;
  logic              inflight;
  logic              inflight_last;
  logic [DATA_W-1:0] skid_data;
  logic              skid_valid;
  logic              skid_last;
  logic [DATA_W-1:0] ram_q;

  logic              crossing;
  logic              trig;
  logic              wr_en;
  logic              pop;
  logic              room;
  logic              rd_issue;
  logic [7:0]        or_next;

  assign STATE = state;

  // At most two words may be held between output, skid and the RAM read in flight.
  always_comb begin
    crossing = prev_valid && ($signed(prev) < $signed(THRESHOLD))
                          && ($signed(ADC_D) >= $signed(THRESHOLD));
    trig     = (state == ARMED) && ADC_VALID && (force_pend || crossing);
    wr_en    = trig || ((state == CAPTURE) && ADC_VALID);
    pop      = RD_VALID && RD_READY;
    if (!RD_VALID || pop) room = !(skid_valid && inflight);
    else                  room = !(skid_valid || inflight);
    rd_issue = (state == READOUT) && !rd_all_issued && room;
    or_next  = (ADC_OR && (OR_COUNT != 8'hFF)) ? OR_COUNT + 8'd1 : OR_COUNT;
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (OSC_50),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (ADC_D),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  always_ff @(posedge OSC_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      prev          <= '0;
      prev_valid    <= 1'b0;
      force_pend    <= 1'b0;
      rd_all_issued <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      skid_data     <= '0;
      skid_valid    <= 1'b0;
      skid_last     <= 1'b0;
      RD_DATA       <= '0;
      RD_VALID      <= 1'b0;
      RD_LAST       <= 1'b0;
      OR_COUNT      <= '0;
      DONE          <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (ARM) begin
            state         <= ARMED;
            OR_COUNT      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            prev_valid    <= 1'b0;
            force_pend    <= 1'b0;
            rd_all_issued <= 1'b0;
            inflight      <= 1'b0;
            skid_valid    <= 1'b0;
            RD_VALID      <= 1'b0;
            RD_LAST       <= 1'b0;
          end
        end
        ARMED: begin
          if (FORCE_TRIG) force_pend <= 1'b1;
          if (trig) begin
            OR_COUNT   <= or_next;
            force_pend <= 1'b0;
            if (LEN == '0) begin
              state <= READOUT;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              state  <= CAPTURE;
            end
          end else if (ADC_VALID) begin
            prev       <= ADC_D;
            prev_valid <= 1'b1;
          end
        end
        CAPTURE: begin
          if (ADC_VALID) begin
            OR_COUNT <= or_next;
            if (wr_ptr == LEN) state  <= READOUT;
            else               wr_ptr <= wr_ptr + 1'b1;
          end
        end
        READOUT: begin
          inflight      <= rd_issue;
          inflight_last <= (rd_ptr == LEN);
          if (rd_issue) begin
            if (rd_ptr == LEN) rd_all_issued <= 1'b1;
            else               rd_ptr        <= rd_ptr + 1'b1;
          end
          // Output register refills from the skid first so words stay in address order.
          if (pop && RD_LAST) begin
            RD_VALID <= 1'b0;
            RD_LAST  <= 1'b0;
            DONE     <= 1'b1;
            state    <= IDLE;
          end else if (!RD_VALID || pop) begin
            if (skid_valid) begin
              RD_DATA    <= skid_data;
              RD_LAST    <= skid_last;
              RD_VALID   <= 1'b1;
              skid_valid <= inflight;
              skid_data  <= ram_q;
              skid_last  <= inflight_last;
            end else if (inflight) begin
              RD_DATA  <= ram_q;
              RD_LAST  <= inflight_last;
              RD_VALID <= 1'b1;
            end else begin
              RD_VALID <= 1'b0;
            end
          end else if (inflight) begin
            skid_data  <= ram_q;
            skid_last  <= inflight_last;
            skid_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: directed scenarios plus randomized captures
// checked against a trigger/readout model built from the capture rules.
module tb_adc_capture;
  import dcc_pkg::*;

  localparam int DW = 14;
  localparam int AW = 8;

  logic          OSC_50 = 1'b0;
  logic          RESET_N = 1'b0;
  logic [DW-1:0] ADC_D = '0;
  logic          ADC_OR = 1'b0;
  logic          ADC_VALID = 1'b0;
  logic          ARM = 1'b0;
  logic          FORCE_TRIG = 1'b0;
  logic [DW-1:0] THRESHOLD = '0;
  logic [AW-1:0] LEN = '0;
  logic [DW-1:0] RD_DATA;
  logic          RD_VALID;
  logic          RD_READY = 1'b0;
  logic          RD_LAST;
  logic [1:0]    STATE;
  logic [7:0]    OR_COUNT;
  logic          DONE;

  always #5 OSC_50 = ~OSC_50;

  adc_capture #(.DATA_W(DW), .DEPTH(256)) dut (
    .OSC_50(OSC_50), .RESET_N(RESET_N), .ADC_D(ADC_D), .ADC_OR(ADC_OR),
    .ADC_VALID(ADC_VALID), .ARM(ARM), .FORCE_TRIG(FORCE_TRIG),
    .THRESHOLD(THRESHOLD), .LEN(LEN), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .RD_READY(RD_READY), .RD_LAST(RD_LAST), .STATE(STATE), .OR_COUNT(OR_COUNT),
    .DONE(DONE)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int enter_cycle = -1;
  int rv_cycle = -1;
  int done_cnt = 0;
  int gap_max = 0;
  logic [1:0] last_state = 2'd0;
  logic [DW-1:0] exp_q[$];
  int exp_or;

  // Advance one clock; outputs are observed 1ns after the rising edge.
  task automatic tick();
    @(posedge OSC_50);
    #1;
    cycle++;
    if (STATE == 2'd3 && last_state != 2'd3) begin
      enter_cycle = cycle;
      rv_cycle = -1;
    end
    if (STATE == 2'd3 && RD_VALID && rv_cycle < 0) rv_cycle = cycle;
    if (DONE) done_cnt++;
    last_state = STATE;
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 16000)) - 8000;
  endfunction

  // Reference: index of the triggering sample in the valid-sample stream.
  function automatic int find_trig(input int thr, input bit frc, input int s[$]);
    if (frc) return 0;
    for (int i = 1; i < s.size(); i++)
      if (s[i-1] < thr && s[i] >= thr) return i;
    return -1;
  endfunction

  task automatic send(input int v, input bit o);
    int gaps;
    gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (gaps) begin
      ADC_VALID = 1'b0;
      ADC_D = DW'($urandom);
      ADC_OR = 1'($urandom);
      tick();
    end
    ADC_D = v[DW-1:0];
    ADC_OR = o;
    ADC_VALID = 1'b1;
    tick();
    ADC_VALID = 1'b0;
    ADC_OR = 1'b0;
  endtask

  task automatic start_capture(input int thr, input int len, input bit frc,
                               input int s[$], input bit o[$], input int extra,
                               input string name);
    int t;
    int v;
    RD_READY = 1'b0;
    THRESHOLD = thr[DW-1:0];
    LEN = len[AW-1:0];
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    checks++;
    if (STATE !== 2'd1) begin
      errors++;
      $display("[TB] FAIL %s arm_state: got %0d, expected 1", name, STATE);
    end
    if (frc) begin
      FORCE_TRIG = 1'b1;
      tick();
      FORCE_TRIG = 1'b0;
    end
    t = find_trig(thr, frc, s);
    exp_q.delete();
    exp_or = 0;
    if (t < 0) t = 0;
    for (int i = t; i <= t + len && i < s.size(); i++) begin
      v = s[i];
      exp_q.push_back(v[DW-1:0]);
      if (o[i] && exp_or < 255) exp_or++;
    end
    for (int i = 0; i <= t + len && i < s.size(); i++) send(s[i], o[i]);
    for (int i = 0; i < extra; i++) send(rnd_sample(), 1'b1);
  endtask

  // Drain the readout; max_words < 0 drains everything and runs the end-of-capture checks.
  task automatic collect_readout(input bit rand_ready, input int max_words, input string name);
    int idx = 0;
    int gaps = 0;
    bit started = 0;
    bit finished = 0;
    bit accept, stalled;
    logic [DW-1:0] hd;
    logic hl;
    int done_before = done_cnt;
    int n = exp_q.size();
    for (int k = 0; k < 5000 && !finished; k++) begin
      RD_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (RD_VALID) started = 1;
      else if (started) gaps++;
      accept = RD_VALID && RD_READY;
      stalled = RD_VALID && !RD_READY;
      hd = RD_DATA;
      hl = RD_LAST;
      if (accept) begin
        checks++;
        if (idx >= n || RD_DATA !== exp_q[idx] || RD_LAST !== (idx == n - 1)) begin
          errors++;
          $display("[TB] FAIL %s word%0d: got data %0d last %0d, expected data %0d last %0d",
                   name, idx, $signed(RD_DATA), RD_LAST,
                   (idx < n) ? $signed(exp_q[idx]) : 0, (idx == n - 1));
        end
        idx++;
      end
      tick();
      if (stalled) begin
        checks++;
        if (RD_VALID !== 1'b1 || RD_DATA !== hd || RD_LAST !== hl) begin
          errors++;
          $display("[TB] FAIL %s stall_hold: got valid %0d data %0d, expected valid 1 data %0d",
                   name, RD_VALID, $signed(RD_DATA), $signed(hd));
        end
      end
      if (max_words >= 0 && idx >= max_words) finished = 1;
      else if (accept && idx >= n) begin
        finished = 1;
        checks++;
        if (STATE !== 2'd0 || DONE !== 1'b1) begin
          errors++;
          $display("[TB] FAIL %s done_idle: got state %0d done %0d, expected state 0 done 1",
                   name, STATE, DONE);
        end
      end
    end
    RD_READY = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("[TB] FAIL %s timeout: got %0d words, expected %0d", name, idx, n);
      return;
    end
    if (max_words >= 0) return;
    checks++;
    if (rv_cycle - enter_cycle !== 2) begin
      errors++;
      $display("[TB] FAIL %s first_valid_latency: got %0d, expected 2", name, rv_cycle - enter_cycle);
    end
    checks++;
    if (OR_COUNT !== exp_or[7:0]) begin
      errors++;
      $display("[TB] FAIL %s or_count: got %0d, expected %0d", name, OR_COUNT, exp_or);
    end
    if (!rand_ready) begin
      checks++;
      if (gaps !== 0) begin
        errors++;
        $display("[TB] FAIL %s bubbles: got %0d, expected 0", name, gaps);
      end
    end
    tick();
    checks++;
    if (DONE !== 1'b0 || done_cnt - done_before !== 1) begin
      errors++;
      $display("[TB] FAIL %s done_pulse: got done %0d pulses %0d, expected 0 and 1",
               name, DONE, done_cnt - done_before);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(posedge OSC_50);
    #1;
    checks++;
    if (STATE !== 2'd0 || RD_VALID !== 1'b0 || RD_LAST !== 1'b0 || DONE !== 1'b0 ||
        OR_COUNT !== 8'd0 || RD_DATA !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: got state %0d valid %0d last %0d done %0d or %0d data %0d, expected all 0",
               STATE, RD_VALID, RD_LAST, DONE, OR_COUNT, RD_DATA);
    end
    RESET_N = 1'b1;
    repeat (2) tick();
    checks++;
    if (STATE !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_release: got state %0d, expected 0", STATE);
    end
  endtask

  task automatic test_ignored_inputs();
    FORCE_TRIG = 1'b1;
    tick();
    FORCE_TRIG = 1'b0;
    for (int i = 0; i < 4; i++) send(rnd_sample(), 1'b1);
    checks++;
    if (STATE !== 2'd0 || OR_COUNT !== 8'd0) begin
      errors++;
      $display("[TB] FAIL idle_ignore: got state %0d or %0d, expected 0 and 0", STATE, OR_COUNT);
    end
  endtask

  task automatic test_ramp();
    int s[$];
    bit o[$];
    s = '{90, 95, 99, 100, 101, 102, 103};
    o = '{0, 0, 0, 0, 1, 0, 0};
    gap_max = 0;
    start_capture(100, 3, 1'b0, s, o, 2, "ramp");
    ARM = 1'b1;
    FORCE_TRIG = 1'b1;
    tick();
    ARM = 1'b0;
    FORCE_TRIG = 1'b0;
    checks++;
    if (STATE !== 2'd3) begin
      errors++;
      $display("[TB] FAIL arm_in_readout: got state %0d, expected 3", STATE);
    end
    collect_readout(1'b0, -1, "ramp");
  endtask

  task automatic test_first_sample();
    int s[$];
    bit o[$];
    s = '{500, 50, 150, 160};
    o = '{1, 1, 0, 0};
    gap_max = 1;
    start_capture(100, 1, 1'b0, s, o, 0, "first_sample");
    collect_readout(1'b0, -1, "first_sample");
  endtask

  task automatic test_force();
    int s[$];
    bit o[$];
    s = '{7, 8};
    o = '{0, 0};
    gap_max = 2;
    start_capture(8000, 1, 1'b1, s, o, 0, "force");
    collect_readout(1'b0, -1, "force");
  endtask

  task automatic test_full_length();
    int s[$];
    bit o[$];
    s = '{0, 200};
    for (int i = 0; i < 255; i++) s.push_back(rnd_sample());
    for (int i = 0; i < s.size(); i++) o.push_back(1'b1);
    gap_max = 0;
    start_capture(100, 255, 1'b0, s, o, 0, "full_len");
    collect_readout(1'b0, -1, "full_len");
  endtask

  task automatic test_random_stall();
    int s[$];
    bit o[$];
    s = '{-50, 120};
    for (int i = 0; i < 20; i++) s.push_back(rnd_sample());
    for (int i = 0; i < s.size(); i++) o.push_back(1'($urandom));
    gap_max = 2;
    start_capture(0, 20, 1'b0, s, o, 1, "stall");
    collect_readout(1'b1, -1, "stall");
  endtask

  task automatic test_reset_mid_readout();
    int s[$];
    bit o[$];
    s = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    o = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    gap_max = 0;
    start_capture(2, 7, 1'b0, s, o, 0, "reset_mid");
    collect_readout(1'b0, 2, "reset_mid");
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (STATE !== 2'd0 || RD_VALID !== 1'b0 || OR_COUNT !== 8'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got state %0d valid %0d or %0d, expected 0 0 0",
               STATE, RD_VALID, OR_COUNT);
    end
    repeat (2) tick();
    RESET_N = 1'b1;
    repeat (3) tick();
    checks++;
    if (STATE !== 2'd0 || RD_VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got state %0d valid %0d, expected 0 0", STATE, RD_VALID);
    end
    start_capture(2, 7, 1'b0, s, o, 0, "recapture");
    collect_readout(1'b0, -1, "recapture");
  endtask

  task automatic test_random();
    int s[$];
    bit o[$];
    int thr, len, k;
    for (int it = 0; it < 6; it++) begin
      s.delete();
      o.delete();
      len = (it == 0) ? 0 : int'($urandom_range(1, 20));
      thr = int'($urandom_range(0, 6000)) - 3000;
      k = int'($urandom_range(1, 6));
      for (int i = 0; i < k; i++) s.push_back(rnd_sample());
      s.push_back(thr - 1 - int'($urandom_range(0, 50)));
      s.push_back(thr + int'($urandom_range(0, 50)));
      for (int i = 0; i <= len; i++) s.push_back(rnd_sample());
      for (int i = 0; i < s.size(); i++) o.push_back(1'($urandom));
      gap_max = int'($urandom_range(0, 2));
      start_capture(thr, len, it == 3, s, o, 1, $sformatf("rand%0d", it));
      collect_readout(it[0], -1, $sformatf("rand%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_ignored_inputs();
    test_ramp();
    test_first_sample();
    test_force();
    test_full_length();
    test_random_stall();
    test_reset_mid_readout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
